cardinal_nic_ctrl: RTL

Network interface controller between one processing element and its local mesh4x4 router port. It buffers outgoing packets written by the PE and injects them onto the router's PE-input channel only in the virtual-channel phase matching the packet's VC bit. It accepts ejected packets into an input buffer that the PE drains through a 4-word register map. There are 16 instances, one per mesh node, inside the NIC/PE wrapper.

---
 rtl/cardinal_nic_pkg.sv | 14 +
 rtl/cardinal_nic_ctrl_if.sv | 29 ++
 rtl/cardinal_nic_ctrl_fifo.sv | 48 ++++
 rtl/cardinal_nic_ctrl.sv | 59 +++++
 4 files changed

// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: shared constants for the cardinal NIC controller
// Holds the PE register map, default widths and status-word field positions.
package cardinal_nic_pkg;
    typedef logic [1:0] nic_addr_t;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int DEPTH_DEF      = 2;
    localparam int VC_BIT_DEF     = 63;
    localparam nic_addr_t ADDR_IN_BUF   = 2'b00;
    localparam nic_addr_t ADDR_IN_STAT  = 2'b01;
    localparam nic_addr_t ADDR_OUT_BUF  = 2'b10;
    localparam nic_addr_t ADDR_OUT_STAT = 2'b11;
    localparam int STAT_FLAG_BIT = 0;
    localparam int STAT_CNT_W    = 32;
endpackage

// File: rtl/cardinal_nic_ctrl_if.sv
// cardinal_nic_ctrl_if: PE register bus plus router inject/eject channels
// slave  = NIC side (drives d_out, net_so, net_do, net_ri)
// master = PE/router side (drives everything else)
interface cardinal_nic_ctrl_if
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    nic_addr_t             addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;
    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );
    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/cardinal_nic_ctrl_fifo.sv
// nic_fifo: circular packet buffer with flush-on-reset
// Ports: clk, reset (async active-low), push, pop, din, head, full, empty.
// A push while full is taken only when the same cycle also pops.
module nic_fifo
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic wr, rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push & (~full | pop);
    assign rd    = pop & ~empty;
    assign head  = mem[rd_ptr];
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (rd) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/cardinal_nic_ctrl.sv
// cardinal_nic_ctrl: NIC between one PE and its mesh router port
// Ports: clk, reset (async active-low), bus (cardinal_nic_ctrl_if.slave):
//   PE side addr/d_in/d_out/nicEn/nicWrEn, inject net_so/net_ro/net_do/net_polarity,
//   eject net_si/net_ri/net_di.
// Optional: define CARDINAL_NIC_STATS_EN to add 32-bit tx/rx packet counters
// in the upper bits of the status words.
module cardinal_nic_ctrl
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int VC_BIT     = VC_BIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    cardinal_nic_ctrl_if.slave  bus
);
    logic [DATA_WIDTH-1:0] out_head, in_head, in_stat, out_stat;
    logic out_full, out_empty, in_full, in_empty;
    logic pe_rd, out_push, in_pop, in_push;
    assign pe_rd    = bus.nicEn & ~bus.nicWrEn;
    assign out_push = bus.nicEn & bus.nicWrEn & (bus.addr == ADDR_OUT_BUF);
    assign in_pop   = pe_rd & (bus.addr == ADDR_IN_BUF);
    // Only inject in the router phase that matches the packet's VC; head blocks the rest.
    assign bus.net_so = ~out_empty & bus.net_ro & (out_head[VC_BIT] == bus.net_polarity);
    assign bus.net_do = out_empty ? '0 : out_head;
    // Reset gates ready directly so it is low throughout reset, not just after it.
    assign bus.net_ri = ~in_full & reset;
    assign in_push    = bus.net_si & bus.net_ri;
    nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_out (
        .clk(clk), .reset(reset), .push(out_push), .pop(bus.net_so),
        .din(bus.d_in), .head(out_head), .full(out_full), .empty(out_empty)
    );
    nic_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_in (
        .clk(clk), .reset(reset), .push(in_push), .pop(in_pop),
        .din(bus.net_di), .head(in_head), .full(in_full), .empty(in_empty)
    );
`ifdef CARDINAL_NIC_STATS_EN
    logic [STAT_CNT_W-1:0] tx_count, rx_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            tx_count <= tx_count + STAT_CNT_W'(bus.net_so);
            rx_count <= rx_count + STAT_CNT_W'(in_push);
        end
    end
    assign in_stat  = {rx_count, {(DATA_WIDTH-STAT_CNT_W-1){1'b0}}, ~in_empty};
    assign out_stat = {tx_count, {(DATA_WIDTH-STAT_CNT_W-1){1'b0}}, out_full};
`else
    assign in_stat  = {{(DATA_WIDTH-1){1'b0}}, ~in_empty};
    assign out_stat = {{(DATA_WIDTH-1){1'b0}}, out_full};
`endif
    assign bus.d_out = !pe_rd                        ? '0 :
                       bus.addr == ADDR_IN_BUF       ? (in_empty ? '0 : in_head) :
                       bus.addr == ADDR_IN_STAT      ? in_stat :
                       bus.addr == ADDR_OUT_STAT     ? out_stat : '0;
endmodule
